// File: rtl/rhd_spi_responder.sv
// ---------------------------------------------------------------------------
// rhd_spi_responder
//
// RHD2000-style SPI slave: the headstage end of the RHD SPI link, used for
// loopback and bench emulation. Receives 16-bit MOSI command words, keeps a
// 64 x 8 register file and returns a two-frame-latency DDR reply on MISO
// (A bit while SCLK is low, B bit while SCLK is high).
//
// Parameters:
//   SYNC_STAGES      synchroniser depth on SCLK/CS/MOSI (legal 2..4)
//   REG_RESET_VALUE  reset content of every register file entry
//
// Ports:
//   clk, rstn        system clock, asynchronous active-low reset
//   SCLK, CS, MOSI   SPI inputs from the master (SCLK <= clk/8, idles low)
//   MISO             DDR reply bit
//   conv_req         one-cycle pulse when a CONVERT frame completes
//   conv_channel     channel field of the last CONVERT
//   conv_a_data      A-side sample, captured on the conv_req cycle
//   conv_b_data      B-side sample, captured on the conv_req cycle
//   frame_valid      one-cycle pulse per complete 16-bit frame
//   frame_cmd        last complete command word
//   frame_err        one-cycle pulse when CS rises after 1..15 bits
//
// Optional feature macro: RHD_RESP_ROM_EN
//   When defined, addresses 40..44 read "INTAN" and address 63 reads the
//   chip ID 8'h01; writes to those addresses are ignored.
// ---------------------------------------------------------------------------
module rhd_spi_responder #(
   parameter int unsigned SYNC_STAGES     = 2,
   parameter logic [7:0]  REG_RESET_VALUE = 8'h00
) (
   input  logic        clk,
   input  logic        rstn,
   input  logic        SCLK,
   input  logic        CS,
   input  logic        MOSI,
   output logic        MISO,
   output logic        conv_req,
   output logic [5:0]  conv_channel,
   input  logic [15:0] conv_a_data,
   input  logic [15:0] conv_b_data,
   output logic        frame_valid,
   output logic [15:0] frame_cmd,
   output logic        frame_err
);

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_SHIFT,
      ST_DECODE
   } state_t;

   state_t state, state_next;

   logic [SYNC_STAGES-1:0] sclk_sync, cs_sync, mosi_sync;
   logic        sclk_d, cs_d;
   logic        sclk_s, cs_s, mosi_s;
   logic        sclk_rise, sclk_fall, cs_rise, cs_fall;

   logic [4:0]  bit_cnt;
   logic [15:0] shift_in;
   logic [15:0] out_a, out_b;
   logic [15:0] stage0_a, stage0_b, stage1_a, stage1_b;
   logic        cs_pend;
   logic [7:0]  regs [64];

   logic        start_frame, do_rise, do_fall, do_abort, do_decode;
   logic [5:0]  addr;
   logic [7:0]  rd_data;
   logic        rom_hit;
   logic [7:0]  rom_val;
   logic        reg_we;
   logic [15:0] reply_a, reply_b;

   // The CS chain resets low so that a CS already low when reset releases
   // (an aborted frame) produces no falling edge; the responder then waits
   // for the next genuine CS fall.
   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         sclk_sync <= '0;
         cs_sync   <= '0;
         mosi_sync <= '0;
         sclk_d    <= 1'b0;
         cs_d      <= 1'b0;
      end else begin
         sclk_sync <= {sclk_sync[SYNC_STAGES-2:0], SCLK};
         cs_sync   <= {cs_sync[SYNC_STAGES-2:0], CS};
         mosi_sync <= {mosi_sync[SYNC_STAGES-2:0], MOSI};
         sclk_d    <= sclk_s;
         cs_d      <= cs_s;
      end
   end

   assign sclk_s    = sclk_sync[SYNC_STAGES-1];
   assign cs_s      = cs_sync[SYNC_STAGES-1];
   assign mosi_s    = mosi_sync[SYNC_STAGES-1];
   assign sclk_rise = sclk_s & ~sclk_d;
   assign sclk_fall = ~sclk_s & sclk_d;
   assign cs_rise   = cs_s & ~cs_d;
   assign cs_fall   = ~cs_s & cs_d;

   // State register
   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) state <= ST_IDLE;
      else       state <= state_next;
   end

   // Next-state and action strobes. CS rise outranks any SCLK edge seen in
   // the same cycle, and edges after the 16th bit are ignored.
   always_comb begin
      state_next  = state;
      start_frame = 1'b0;
      do_rise     = 1'b0;
      do_fall     = 1'b0;
      do_abort    = 1'b0;
      do_decode   = 1'b0;
      case (state)
         ST_IDLE: begin
            if (cs_fall || cs_pend) begin
               start_frame = 1'b1;
               state_next  = ST_SHIFT;
            end
         end
         ST_SHIFT: begin
            if (cs_rise) begin
               if (bit_cnt == 5'd16) begin
                  state_next = ST_DECODE;
               end else begin
                  do_abort   = 1'b1;
                  state_next = ST_IDLE;
               end
            end else if (sclk_rise && (bit_cnt < 5'd16)) begin
               do_rise = 1'b1;
            end else if (sclk_fall && (bit_cnt < 5'd16)) begin
               do_fall = 1'b1;
            end
         end
         ST_DECODE: begin
            do_decode  = 1'b1;
            state_next = ST_IDLE;
         end
         default: state_next = ST_IDLE;
      endcase
   end

   assign addr = shift_in[13:8];

   // Read-only overlay: a hit replaces both the read data and the data field
   // of a WRITE reply, and blocks the register write.
`ifdef RHD_RESP_ROM_EN
   always_comb begin
      rom_hit = 1'b1;
      rom_val = 8'h00;
      case (addr)
         6'd40:   rom_val = 8'h49;
         6'd41:   rom_val = 8'h4E;
         6'd42:   rom_val = 8'h54;
         6'd43:   rom_val = 8'h41;
         6'd44:   rom_val = 8'h4E;
         6'd63:   rom_val = 8'h01;
         default: rom_hit = 1'b0;
      endcase
   end
`else
   assign rom_hit = 1'b0;
   assign rom_val = 8'h00;
`endif

   assign rd_data = rom_hit ? rom_val : regs[addr];

   // Reply word for the command currently held in shift_in
   always_comb begin
      reg_we  = 1'b0;
      reply_a = 16'h0000;
      reply_b = 16'h0000;
      case (shift_in[15:14])
         2'b10: begin
            reg_we  = ~rom_hit;
            reply_a = {8'hFF, (rom_hit ? rom_val : shift_in[7:0])};
            reply_b = reply_a;
         end
         2'b11: begin
            reply_a = {8'h00, rd_data};
            reply_b = reply_a;
         end
         2'b00: begin
            reply_a = conv_a_data;
            reply_b = conv_b_data;
         end
         default: begin
            if ((shift_in == 16'h5500) || (shift_in == 16'h6A00)) begin
               reply_a = 16'h8000;
               reply_b = 16'h8000;
            end
         end
      endcase
   end

   // Frame datapath: shift in/out, reply pipeline and status pulses.
   // A CS fall that lands during DECODE is remembered in cs_pend.
   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         bit_cnt      <= 5'd0;
         shift_in     <= 16'h0000;
         out_a        <= 16'h0000;
         out_b        <= 16'h0000;
         stage0_a     <= 16'h0000;
         stage0_b     <= 16'h0000;
         stage1_a     <= 16'h0000;
         stage1_b     <= 16'h0000;
         MISO         <= 1'b0;
         cs_pend      <= 1'b0;
         frame_valid  <= 1'b0;
         frame_err    <= 1'b0;
         frame_cmd    <= 16'h0000;
         conv_req     <= 1'b0;
         conv_channel <= 6'd0;
      end else begin
         frame_valid <= 1'b0;
         frame_err   <= 1'b0;
         conv_req    <= 1'b0;
         if (cs_fall && (state == ST_DECODE)) cs_pend <= 1'b1;
         else if (start_frame)                cs_pend <= 1'b0;
         if (start_frame) begin
            out_a   <= stage0_a;
            out_b   <= stage0_b;
            MISO    <= stage0_a[15];
            bit_cnt <= 5'd0;
         end
         if (do_rise) begin
            shift_in <= {shift_in[14:0], mosi_s};
            MISO     <= out_b[4'd15 - bit_cnt[3:0]];
            bit_cnt  <= bit_cnt + 5'd1;
         end
         if (do_fall) MISO <= out_a[4'd15 - bit_cnt[3:0]];
         if (do_abort) begin
            MISO      <= 1'b0;
            frame_err <= (bit_cnt != 5'd0);
         end
         if (do_decode) begin
            MISO        <= 1'b0;
            frame_valid <= 1'b1;
            frame_cmd   <= shift_in;
            stage0_a    <= stage1_a;
            stage0_b    <= stage1_b;
            stage1_a    <= reply_a;
            stage1_b    <= reply_b;
            if (shift_in[15:14] == 2'b00) begin
               conv_req     <= 1'b1;
               conv_channel <= shift_in[13:8];
            end
         end
      end
   end

   // Register file
   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         for (int i = 0; i < 64; i++) regs[i] <= REG_RESET_VALUE;
      end else if (do_decode && reg_we) begin
         regs[addr] <= shift_in[7:0];
      end
   end

endmodule

// File: doc/rhd_spi_responder.md
Name: rhd_spi_responder

Overview:
- Synthesizable RHD2000-style SPI slave; the far end of the RHD SPI master link.
- Used for loopback or bench emulation of the headstage.
- Decodes 16-bit MOSI commands and holds a 64 x 8 register file.
- Returns a DDR MISO reply on a single wire (A word and B word, interleaved per SCLK), with RHD two-frame reply latency. Conversion data comes from ports.

Parameters:
- SYNC_STAGES, 2: synchroniser depth on SCLK/CS/MOSI; legal values 2..4.
- REG_RESET_VALUE, 8'h00: reset content of every register file entry.

Ports:
- clk, input, 1: system clock; SCLK is at most clk/8.
- rstn, input, 1: asynchronous active-low reset.
- SCLK, input, 1: SPI clock from master; idles low.
- CS, input, 1: active-low chip select.
- MOSI, input, 1: command bit stream, MSB first.
- MISO, output, 1: DDR reply; A bit then B bit per SCLK period.
- conv_req, output, 1: one-cycle pulse when a CONVERT frame completes.
- conv_channel, output, 6: channel field of that CONVERT.
- conv_a_data, input, 16: A-side sample, captured on the conv_req cycle.
- conv_b_data, input, 16: B-side sample, captured on the conv_req cycle.
- frame_valid, output, 1: one-cycle pulse for each complete 16-bit frame.
- frame_cmd, output, 16: last complete command word; held until the next frame.
- frame_err, output, 1: one-cycle pulse when CS rises after 1..15 bits.

Behaviour:
- Reset values: MISO=0, conv_req=0, conv_channel=0, frame_valid=0, frame_cmd=0, frame_err=0. Registers = REG_RESET_VALUE. Both reply pipeline stages = 0. Bit counter = 0.
- Reset asserted mid-frame aborts the frame immediately; after rstn rises, wait for the next CS falling edge.
- Input path: SCLK, CS and MOSI each pass through SYNC_STAGES flops, then a 1-flop edge detector. Every action below happens on the clk cycle after the synchronised edge.
- FSM states:
  - IDLE: on CS fall, load the shift-out register from reply stage 0, drive MISO=A[15], clear the bit counter, go to SHIFT.
  - SHIFT, on SCLK rise (bit counter < 16): shift in MOSI; MISO = B[15-k]; k = k+1.
  - SHIFT, on SCLK fall (k < 16): MISO = A[15-k].
  - SHIFT, SCLK edges after k = 16: ignored; MISO held.
  - SHIFT, on CS rise: if k == 16, go to DECODE; otherwise pulse frame_err and go to IDLE with no pipeline advance.
  - DECODE (one cycle): pulse frame_valid, update frame_cmd, form the reply word, advance the pipeline, go to IDLE. MISO=0.
- Command decode, with c = received word:
  - c[15:14]=2'b10, WRITE: reg[c[13:8]] <= c[7:0]. Reply A=B={8'hFF, c[7:0]}.
  - c[15:14]=2'b11, READ: reply A=B={8'h00, reg[c[13:8]]}.
  - c[15:14]=2'b00, CONVERT: pulse conv_req, conv_channel=c[13:8]. Reply A=conv_a_data, B=conv_b_data, sampled that cycle.
  - c == 16'h5500, CALIBRATE: reply 16'h8000 on both A and B.
  - c == 16'h6A00, CLEAR: reply 16'h8000 on both A and B.
  - Any other 01xx word: reply 16'h0000 on both A and B.
- WRITE followed by READ of the same address in the next frame returns the new value.
- Reply pipeline: on DECODE, stage0 <= stage1 and stage1 <= new reply. Reply to frame N is shifted out during frame N+2. Aborted frames do not advance it.
- CS rise and SCLK edge in the same cycle: CS takes priority; the SCLK edge is discarded.
- CS fall while in DECODE cannot occur (the SCLK ratio guarantees this); the FSM still accepts it on the next IDLE cycle.

Optional Feature:
- Macro RHD_RESP_ROM_EN.
- Defined:
  - Addresses 40..44 read-only ASCII "INTAN" (8'h49, 8'h4E, 8'h54, 8'h41, 8'h4E).
  - Address 63 reads 8'h01 (chip ID).
  - WRITE to these addresses leaves them unchanged; the reply data field is the ROM value.
- Undefined: all 64 addresses are ordinary read/write registers.

Test Plan:
- Reset, then CS held high: MISO=0, frame_valid never pulses, frame_cmd=0.
- Frames WRITE 16'h8A5C, READ 16'hCA00, dummy 16'hFFFF, dummy: frame 3 MISO A=B=16'hFF5C; frame 4 A=B=16'h005C.
- CONVERT 16'h0500 with conv_a_data=16'h1234, conv_b_data=16'hABCD: conv_req pulses with conv_channel=5; two frames later MISO A=16'h1234, B=16'hABCD.
- CS raised after 9 SCLKs: frame_err pulses, frame_valid stays 0. The next full frame's reply is unchanged from the pre-abort pipeline.
- rstn dropped mid-frame: MISO=0 and registers = REG_RESET_VALUE immediately. The next full READ frame is followed two frames later by reply 16'h0000.
- With RHD_RESP_ROM_EN: READ 16'hE800 (addr 40) gives 16'h0049 two frames later. WRITE 16'hA8FF gives 16'hFF49, and a later read of addr 40 is still 8'h49.
